// File: rtl/csr_regfile.sv
// Machine-mode CSR file: mcountinhibit, mscratch, mepc, 64-bit mcycle/minstret and their user-mode read-only shadows.
// Latency: reads and illegal flag are combinational (0 cycles); writes commit on the rising edge and are visible the next cycle.
// Backpressure: none; the write port is fire-and-forget, one write per cycle, always accepted or silently discarded.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   csr_addr_i/csr_access_i  read address and "CSR instruction present" qualifier
//   csr_data_o               current value at csr_addr_i (0 for unimplemented)
//   csr_we_i/csr_waddr_i/csr_wdata_i  writeback commit port
//   retire_i                 one instruction retires this cycle
//   csr_illegal_o            illegal read (unimplemented) or illegal write (read-only/unimplemented)
module csr_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [11:0]      csr_addr_i,
  input  logic             csr_access_i,
  output logic [WIDTH-1:0] csr_data_o,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_waddr_i,
  input  logic [WIDTH-1:0] csr_wdata_i,
  input  logic             retire_i,
  output logic             csr_illegal_o
);

  localparam logic [2*WIDTH-1:0] CNT_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic                 r_cy_inh;
  logic                 r_ir_inh;
  logic [WIDTH-1:0]     r_mscratch;
  logic [WIDTH-3:0]     r_mepc;      // bits [1:0] are hardwired to zero
  logic [2*WIDTH-1:0]   r_mcycle;
  logic [2*WIDTH-1:0]   r_minstret;

  logic [WIDTH-1:0]     w_rdata;
  logic                 w_wr_inh;
  logic                 w_wr_scratch;
  logic                 w_wr_epc;
  logic                 w_wr_cyc_lo;
  logic                 w_wr_cyc_hi;
  logic                 w_wr_ins_lo;
  logic                 w_wr_ins_hi;

  function automatic logic f_implemented(input logic [11:0] a);
    case (a)
      12'h320, 12'h340, 12'h341,
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: f_implemented = 1'b1;
      default:                             f_implemented = 1'b0;
    endcase
  endfunction

  // Write strobes only decode writable addresses, so writes to the 0xCxx
  // shadows or unimplemented addresses fall through and are discarded.
  assign w_wr_inh     = csr_we_i && (csr_waddr_i == 12'h320);
  assign w_wr_scratch = csr_we_i && (csr_waddr_i == 12'h340);
  assign w_wr_epc     = csr_we_i && (csr_waddr_i == 12'h341);
  assign w_wr_cyc_lo  = csr_we_i && (csr_waddr_i == 12'hB00);
  assign w_wr_cyc_hi  = csr_we_i && (csr_waddr_i == 12'hB80);
  assign w_wr_ins_lo  = csr_we_i && (csr_waddr_i == 12'hB02);
  assign w_wr_ins_hi  = csr_we_i && (csr_waddr_i == 12'hB82);

  always_comb begin
    w_rdata = '0;
    case (csr_addr_i)
      12'h320:          w_rdata = {{(WIDTH-3){1'b0}}, r_ir_inh, 1'b0, r_cy_inh};
      12'h340:          w_rdata = r_mscratch;
      12'h341:          w_rdata = {r_mepc, 2'b00};
      12'hB00, 12'hC00: w_rdata = r_mcycle[WIDTH-1:0];
      12'hB80, 12'hC80: w_rdata = r_mcycle[2*WIDTH-1:WIDTH];
      12'hB02, 12'hC02: w_rdata = r_minstret[WIDTH-1:0];
      12'hB82, 12'hC82: w_rdata = r_minstret[2*WIDTH-1:WIDTH];
      default:          w_rdata = '0;
    endcase
  end

  assign csr_data_o = w_rdata;

  assign csr_illegal_o = (csr_access_i && !f_implemented(csr_addr_i)) ||
                         (csr_we_i && ((csr_waddr_i[11:10] == 2'b11) ||
                                       !f_implemented(csr_waddr_i)));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cy_inh   <= 1'b0;
      r_ir_inh   <= 1'b0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      // Inhibit bits are sampled before this edge's write lands, so a
      // counter still ticks in the cycle that sets its inhibit bit.
      if (w_wr_inh) begin
        r_cy_inh <= csr_wdata_i[0];
        r_ir_inh <= csr_wdata_i[2];
      end
      if (w_wr_scratch) r_mscratch <= csr_wdata_i;
      if (w_wr_epc)     r_mepc     <= csr_wdata_i[WIDTH-1:2];

      // A write to either half suppresses that counter's increment.
      if (w_wr_cyc_lo)      r_mcycle[WIDTH-1:0]       <= csr_wdata_i;
      else if (w_wr_cyc_hi) r_mcycle[2*WIDTH-1:WIDTH] <= csr_wdata_i;
      else if (!r_cy_inh)   r_mcycle                  <= r_mcycle + CNT_ONE;

      if (w_wr_ins_lo)                r_minstret[WIDTH-1:0]       <= csr_wdata_i;
      else if (w_wr_ins_hi)           r_minstret[2*WIDTH-1:WIDTH] <= csr_wdata_i;
      else if (retire_i && !r_ir_inh) r_minstret                  <= r_minstret + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus a randomized run against a reference model.
// Latency: model updates at each rising edge; outputs are sampled a few ns after the edge.
// Backpressure: none; the bench drives one write per cycle at most.
module tb_csr_regfile;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [11:0] csr_addr_i;
  logic        csr_access_i;
  logic [31:0] csr_data_o;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        retire_i;
  logic        csr_illegal_o;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [63:0] m_cyc;
  logic [63:0] m_ins;
  logic        m_cy;
  logic        m_ir;
  logic [31:0] m_scr;
  logic [31:0] m_epc;

  logic [11:0] impl [11] = '{12'h320, 12'h340, 12'h341, 12'hB00, 12'hB80, 12'hB02,
                             12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};

  csr_regfile #(.WIDTH(32)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .csr_addr_i   (csr_addr_i),
    .csr_access_i (csr_access_i),
    .csr_data_o   (csr_data_o),
    .csr_we_i     (csr_we_i),
    .csr_waddr_i  (csr_waddr_i),
    .csr_wdata_i  (csr_wdata_i),
    .retire_i     (retire_i),
    .csr_illegal_o(csr_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_impl(input logic [11:0] a);
    foreach (impl[i]) if (impl[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h320:          return {29'd0, m_ir, 1'b0, m_cy};
      12'h340:          return m_scr;
      12'h341:          return m_epc & 32'hFFFF_FFFC;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default:          return 32'd0;
    endcase
  endfunction

  function automatic logic m_illegal();
    return (csr_access_i && !is_impl(csr_addr_i)) ||
           (csr_we_i && (csr_waddr_i[11:10] == 2'b11 || !is_impl(csr_waddr_i)));
  endfunction

  function automatic void m_reset();
    m_cyc = 0; m_ins = 0; m_cy = 0; m_ir = 0; m_scr = 0; m_epc = 0;
  endfunction

  // One clock edge of architectural behaviour.
  function automatic void m_update();
    logic        new_cy, new_ir;
    logic [63:0] nc, ni;
    new_cy = m_cy; new_ir = m_ir;
    nc = m_cyc; ni = m_ins;
    if (!m_cy) nc = m_cyc + 64'd1;
    if (retire_i && !m_ir) ni = m_ins + 64'd1;
    if (csr_we_i) begin
      case (csr_waddr_i)
        12'h320: begin new_cy = csr_wdata_i[0]; new_ir = csr_wdata_i[2]; end
        12'h340: m_scr = csr_wdata_i;
        12'h341: m_epc = csr_wdata_i;
        12'hB00: nc = {m_cyc[63:32], csr_wdata_i};
        12'hB80: nc = {csr_wdata_i, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], csr_wdata_i};
        12'hB82: ni = {csr_wdata_i, m_ins[31:0]};
        default: ;
      endcase
    end
    m_cyc = nc; m_ins = ni; m_cy = new_cy; m_ir = new_ir;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    if (!reset_i) m_update();
    #1;
  endtask

  task automatic idle();
    csr_we_i = 1'b0; csr_access_i = 1'b0; retire_i = 1'b0;
    csr_waddr_i = 12'h000; csr_wdata_i = 32'h0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i = 1'b1; csr_waddr_i = a; csr_wdata_i = d;
    tick();
    csr_we_i = 1'b0;
  endtask

  // Read through the port and compare against both model and illegal flag.
  task automatic check_rd(input string tag, input logic [11:0] a);
    csr_addr_i = a; csr_access_i = 1'b1;
    #1;
    chk(tag, csr_data_o, m_read(a));
    chk({tag, "_ill"}, {31'd0, csr_illegal_o}, {31'd0, m_illegal()});
    csr_access_i = 1'b0;
  endtask

  task automatic check_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr_i = a;
    #1;
    chk(tag, csr_data_o, exp);
  endtask

  initial begin
    m_reset();
    idle();
    csr_addr_i = 12'hB00;
    reset_i = 1'b1;
    #12;
    check_const("rst_b00", 12'hB00, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    check_const("first_cycle", 12'hB00, 32'd0);

    // Free-running cycle counter.
    repeat (10) tick();
    check_const("cyc10", 12'hB00, 32'd10);
    check_const("cych10", 12'hB80, 32'd0);
    check_const("shadow10", 12'hC00, 32'd10);
    chk("ill_idle", {31'd0, csr_illegal_o}, 32'd0);

    // Low-half wrap carries into the high half.
    wr(12'hB00, 32'hFFFF_FFFF);
    check_const("wrap_pre", 12'hB00, 32'hFFFF_FFFF);
    tick();
    check_const("wrap_lo", 12'hB00, 32'd0);
    check_const("wrap_hi", 12'hB80, 32'd1);

    // Inhibit both counters.
    wr(12'h320, 32'h5);
    check_rd("inh_cyc0", 12'hB00);
    retire_i = 1'b1;
    repeat (3) tick();
    retire_i = 1'b0;
    check_rd("inh_cyc", 12'hB00);
    check_rd("inh_ins", 12'hB02);
    check_const("inh_val", 12'h320, 32'h5);
    check_const("inh_ins0", 12'hB02, 32'd0);
    wr(12'h320, 32'h0);
    check_rd("resume0", 12'hB00);
    tick();
    check_rd("resume1", 12'hB00);

    // Plain read/write registers.
    wr(12'h341, 32'hDEAD_BEEF);
    check_const("mepc", 12'h341, 32'hDEAD_BEEC);
    wr(12'h340, 32'h1234_5678);
    check_const("mscratch", 12'h340, 32'h1234_5678);

    // Illegal write to a shadow and illegal read of an unimplemented address.
    csr_we_i = 1'b1; csr_waddr_i = 12'hC00; csr_wdata_i = 32'h55;
    csr_access_i = 1'b1; csr_addr_i = 12'h7C0;
    #1;
    chk("ill_both", {31'd0, csr_illegal_o}, 32'd1);
    chk("rd_7c0", csr_data_o, 32'd0);
    tick();
    csr_we_i = 1'b0;
    #1;
    chk("ill_rd_only", {31'd0, csr_illegal_o}, 32'd1);
    csr_access_i = 1'b0;
    csr_we_i = 1'b1; csr_waddr_i = 12'h123;
    #1;
    chk("ill_wr_only", {31'd0, csr_illegal_o}, 32'd1);
    csr_we_i = 1'b0;
    check_rd("c00_kept", 12'hC00);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 13);
      csr_addr_i = (r < 11) ? impl[r] : 12'($urandom);
      csr_access_i = 1'($urandom);
      r = $urandom_range(0, 13);
      csr_waddr_i = (r < 11) ? impl[r] : 12'($urandom);
      csr_we_i = ($urandom_range(0, 2) == 0);
      if (csr_waddr_i == 12'h320 && $urandom_range(0, 3) != 0) csr_wdata_i = 32'h0;
      else if ($urandom_range(0, 3) == 0) csr_wdata_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else csr_wdata_i = $urandom;
      retire_i = 1'($urandom);
      #1;
      chk("rnd_data", csr_data_o, m_read(csr_addr_i));
      chk("rnd_ill", {31'd0, csr_illegal_o}, {31'd0, m_illegal()});
      tick();
    end
    idle();

    // Asynchronous reset between edges.
    wr(12'h340, 32'hA5A5_A5A5);
    check_const("scr_a5", 12'h340, 32'hA5A5_A5A5);
    #2;
    reset_i = 1'b1;
    m_reset();
    #1;
    chk("async_scr", csr_data_o, 32'd0);
    check_const("async_cyc", 12'hB00, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) tick();
    check_rd("post_rst", 12'hB00);
    check_const("post_rst3", 12'hB00, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode control and status register file for the pipelined core. It sources the current CSR value (`csr_data`) that feeds the CSR ALU and commits the ALU's result back on the write port. It also owns the 64-bit cycle and retired-instruction counters, their inhibit control, and illegal-access detection. It sits between the execute stage (read) and the writeback stage (write).

## Interface
Parameters:
- `WIDTH`, default 32: data width. Only 32 is supported.

Ports:
- `clk_i` input 1: clock. Rising-edge active.
- `reset_i` input 1: reset, asynchronous, active-high.
- `csr_addr_i` input 12: read address.
- `csr_access_i` input 1: a CSR instruction is presenting `csr_addr_i` this cycle.
- `csr_data_o` output WIDTH: current value of the CSR at `csr_addr_i`.
- `csr_we_i` input 1: write enable from writeback.
- `csr_waddr_i` input 12: write address.
- `csr_wdata_i` input WIDTH: write data (the CSR ALU result).
- `retire_i` input 1: one instruction retires this cycle.
- `csr_illegal_o` output 1: illegal CSR access flag.

## Operation
Implemented CSRs (address: behaviour):
- 0x320 `mcountinhibit`: bit0 CY and bit2 IR are read/write. All other bits read 0 and ignore writes.
- 0x340 `mscratch`: full 32-bit read/write.
- 0x341 `mepc`: read/write. Bits [1:0] always read 0 (IALIGN=32).
- 0xB00 / 0xB80 `mcycle` / `mcycleh`: low and high halves of the 64-bit cycle counter. Read/write.
- 0xB02 / 0xB82 `minstret` / `minstreth`: low and high halves of the 64-bit retire counter. Read/write.
- 0xC00 / 0xC80 `cycle` / `cycleh`: read-only shadows of `mcycle` and `mcycleh`.
- 0xC02 / 0xC82 `instret` / `instreth`: read-only shadows of `minstret` and `minstreth`.

Read path:
- `csr_data_o` is combinational from `csr_addr_i` and the registered state.
- An unimplemented address reads 0.
- There is no write-to-read bypass. A same-cycle read of the address being written returns the old value; the pipeline forwarding unit covers this hazard.

Write path:
- On a rising edge with `csr_we_i=1`, the target CSR takes `csr_wdata_i`, with the field masks above applied.
- A write to any read-only address (`csr_waddr_i[11:10]==2'b11`) or to an unimplemented address is discarded.

Counters:
- `mcycle` increments by 1 every cycle while `mcountinhibit.CY=0`.
- `minstret` increments by 1 on each cycle with `retire_i=1` while `mcountinhibit.IR=0`.
- Both are 64-bit and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
- The carry from the low half into the high half is internal and occurs in the same cycle.
- A write to either half of a counter: the written half takes `wdata`, the other half holds its value, and that counter does not increment in that cycle.
- A write to `mcountinhibit` takes effect from the next cycle. The counter still increments in the write cycle if its inhibit bit was 0 before the write.

Illegal detection (combinational, `csr_illegal_o`): asserted when either of these holds.
- `csr_access_i=1` and `csr_addr_i` is unimplemented.
- `csr_we_i=1` and `csr_waddr_i` is read-only or unimplemented.

## Timing
- Asynchronous reset: all CSRs and both counters clear to 0 immediately, including mid-operation. `csr_data_o` reads 0 for every address while reset is held.
- In the first cycle after reset deasserts, `mcycle` reads 0. It reads N after N further rising edges.
- Read latency is 0 cycles (combinational).
- A write is visible on `csr_data_o` the cycle after its commit edge.
- `csr_illegal_o` has 0-cycle latency and is never registered.
- There is no handshake. The write port is fire-and-forget, one write per cycle.

## Test plan
- Reset, release, hold for 10 cycles, read 0xB00 → 10. Read 0xB80 → 0. Read 0xC00 → 10. `csr_illegal_o=0`.
- Write 0xB00=0xFFFF_FFFF, then let 1 cycle pass:
  - Next read of 0xB00 → 0xFFFF_FFFF, then 0x0000_0000.
  - 0xB80 → 1 once the low half has wrapped.
- Write 0x320=0x5, pulse `retire_i` for 3 cycles, then read:
  - 0xB02 and 0xB00 are frozen at their prior values.
  - `mcountinhibit` reads 0x5.
  - Clearing 0x320 resumes counting on the next cycle.
- Write 0x341=0xDEAD_BEEF → reads 0xDEAD_BEEC. Write 0x340=0x1234_5678 → reads 0x1234_5678.
- Write 0xC00=0x55 and access 0x7C0:
  - `csr_illegal_o=1` in both cycles.
  - 0xC00 is unaffected.
  - 0x7C0 reads 0.
- Assert `reset_i` asynchronously between edges with `mscratch`=0xA5A5_A5A5 → `csr_data_o` for 0x340 drops to 0 before the next edge.
